// File: rtl/timeout_counter_bank_pkg.sv
// rtl/timeout_counter_bank_pkg.sv - shared constants and helpers for the timeout counter bank
package timeout_counter_bank_pkg;

  localparam int DEFAULT_TERM = 100;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/timeout_channel.sv
// rtl/timeout_channel.sv - one timeout counter with programmable terminal and sticky expiry
module timeout_channel
  import timeout_counter_bank_pkg::*;
#(
  parameter int              WIDTH      = 7,
  parameter logic [WIDTH-1:0] RESET_TERM = WIDTH'(DEFAULT_TERM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             clear,
  input  logic             periodic,
  input  logic             term_we,
  input  logic [WIDTH-1:0] term_data,
  output logic             time_out,
  output logic             expired,
  output logic [WIDTH-1:0] count_val
);

  logic [WIDTH-1:0] term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term <= RESET_TERM;
    end else if (term_we) begin
      term <= term_data;
    end
  end

  // The compare sees the terminal from before any same-cycle write; >= makes
  // a lowered terminal fire on the next counted cycle instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_val <= '0;
      time_out  <= 1'b0;
      expired   <= 1'b0;
    end else if (clear) begin
      count_val <= '0;
      time_out  <= 1'b0;
      expired   <= 1'b0;
    end else if (!count || expired) begin
      time_out  <= 1'b0;
    end else if (count_val >= term) begin
      count_val <= '0;
      time_out  <= 1'b1;
      if (!periodic) begin
        expired <= 1'b1;
      end
    end else begin
      count_val <= count_val + 1'b1;
      time_out  <= 1'b0;
    end
  end

endmodule

// File: rtl/timeout_counter_bank.sv
// rtl/timeout_counter_bank.sv - bank of independent programmable timeout counters
module timeout_counter_bank
  import timeout_counter_bank_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int NUM_CH       = 1,
  parameter int DEFAULT_TERM = timeout_counter_bank_pkg::DEFAULT_TERM
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             count,
  input  logic [NUM_CH-1:0]             clear,
  input  logic [NUM_CH-1:0]             periodic,
  input  logic                          term_wr,
  input  logic [sel_width(NUM_CH)-1:0]  term_sel,
  input  logic [WIDTH-1:0]              term_data,
  output logic [NUM_CH-1:0]             timeOut,
  output logic [NUM_CH-1:0]             expired,
  output logic [NUM_CH*WIDTH-1:0]       count_val
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] term_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Selects at or beyond NUM_CH match no channel and are dropped.
    assign term_we[i] = term_wr && (term_sel == SEL_W'(i));

    timeout_channel #(
      .WIDTH      (WIDTH),
      .RESET_TERM (WIDTH'(DEFAULT_TERM))
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .count     (count[i]),
      .clear     (clear[i]),
      .periodic  (periodic[i]),
      .term_we   (term_we[i]),
      .term_data (term_data),
      .time_out  (timeOut[i]),
      .expired   (expired[i]),
      .count_val (count_val[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_timeout_counter_bank.sv
// tb/tb_timeout_counter_bank.sv - scoreboard bench for the timeout counter bank
module tb_timeout_counter_bank;
  import timeout_counter_bank_pkg::*;

  localparam int W  = 7;
  localparam int N  = 5;
  localparam int SW = sel_width(N);

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   count, clear, periodic;
  logic           term_wr;
  logic [SW-1:0]  term_sel;
  logic [W-1:0]   term_data;
  logic [N-1:0]   time_out, expired;
  logic [N*W-1:0] count_val;

  timeout_counter_bank #(.WIDTH(W), .NUM_CH(N), .DEFAULT_TERM(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .clear     (clear),
    .periodic  (periodic),
    .term_wr   (term_wr),
    .term_sel  (term_sel),
    .term_data (term_data),
    .timeOut   (time_out),
    .expired   (expired),
    .count_val (count_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; int cyc; bit xp;} pulse_t;
  pulse_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void expect_pulse(input int ch, input int c, input bit xp);
    pulse_t p;
    p.ch = ch; p.cyc = c; p.xp = xp;
    sb.push_back(p);
  endfunction

  function automatic int cv(input int ch);
    return int'(count_val[ch*W +: W]);
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every observed pulse must match a queued expectation.
  always @(negedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      if (time_out[ch]) begin
        int idx;
        idx = -1;
        foreach (sb[k]) if (sb[k].ch == ch && sb[k].cyc == cyc) idx = k;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL pulse_unexpected ch%0d cycle %0d: got timeOut=1, want 0", ch, cyc);
        end else begin
          if (expired[ch] !== sb[idx].xp || count_val[ch*W +: W] !== '0) begin
            errors++;
            $display("FAIL pulse_state ch%0d cycle %0d: got expired=%0b count_val=%0d, want expired=%0b count_val=0",
                     ch, cyc, expired[ch], count_val[ch*W +: W], sb[idx].xp);
          end
          sb.delete(idx);
        end
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL pulse_missed ch%0d: got no timeOut at cycle %0d, want 1", sb[k].ch, sb[k].cyc);
        sb.delete(k);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, want finish");
    $fatal(1);
  end

  initial begin
    int n, m, s;
    reset = 1'b1; count = '0; clear = '0; periodic = '0;
    term_wr = 1'b0; term_sel = '0; term_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_timeout", int'(time_out), 0);
    check("reset_expired", int'(expired), 0);
    check("reset_count_val_nonzero", int'(count_val != '0), 0);
    reset = 1'b0;

    // Default terminal 100, periodic
    n = cyc; count[0] = 1'b1; periodic[0] = 1'b1;
    expect_pulse(0, n + 101, 1'b0);
    expect_pulse(0, n + 202, 1'b0);
    to_cyc(n + 100); check("t1_cv_at_term", cv(0), 100);
    to_cyc(n + 101); check("t1_wrap", cv(0), 0);
    to_cyc(n + 202); count[0] = 1'b0;

    // One-shot T=5, then clear restarts it
    n = cyc; term_wr = 1'b1; term_sel = 3'd1; term_data = 7'd5;
    to_cyc(n + 1); term_wr = 1'b0;
    m = cyc; count[1] = 1'b1; periodic[1] = 1'b0;
    expect_pulse(1, m + 6, 1'b1);
    to_cyc(m + 5);  check("t2_cv_before_fire", cv(1), 5);
    to_cyc(m + 10); check("t2_cv_hold", cv(1), 0);
    check("t2_expired", int'(expired[1]), 1);
    clear[1] = 1'b1;
    to_cyc(m + 11); clear[1] = 1'b0;
    check("t2_cleared", int'(expired[1]), 0);
    expect_pulse(1, m + 17, 1'b1);
    to_cyc(m + 17); count[1] = 1'b0;

    // Toggled count, T=3
    n = cyc; term_wr = 1'b1; term_sel = 3'd2; term_data = 7'd3;
    to_cyc(n + 1); term_wr = 1'b0;
    m = cyc; periodic[2] = 1'b1;
    expect_pulse(2, m + 7, 1'b0);
    for (int k = 0; k < 8; k++) begin
      count[2] = (k % 2 == 0);
      to_cyc(m + k + 1);
      if (k == 1) check("t3_hold_1", cv(2), 1);
      if (k == 5) check("t3_hold_3", cv(2), 3);
    end
    count[2] = 1'b0;

    // Lowering T below c, then T=0
    n = cyc; count[3] = 1'b1; periodic[3] = 1'b1;
    to_cyc(n + 50); check("t4_c50", cv(3), 50);
    term_wr = 1'b1; term_sel = 3'd3; term_data = 7'd10;
    expect_pulse(3, n + 52, 1'b0);
    to_cyc(n + 51); term_wr = 1'b0;
    check("t4_old_term_used", cv(3), 51);
    to_cyc(n + 52); count[3] = 1'b0;
    term_wr = 1'b1; term_sel = 3'd3; term_data = 7'd0;
    to_cyc(n + 53); term_wr = 1'b0; count[3] = 1'b1;
    expect_pulse(3, n + 54, 1'b0);
    expect_pulse(3, n + 55, 1'b0);
    expect_pulse(3, n + 56, 1'b0);
    to_cyc(n + 56); count[3] = 1'b0;
    check("t4_cv_zero", cv(3), 0);

    // Multi-channel independence, ignored selects, clear beats firing
    n = cyc; term_wr = 1'b1; term_sel = 3'd4; term_data = 7'd2;
    to_cyc(n + 1); term_sel = 3'd5; term_data = 7'd1;
    to_cyc(n + 2); term_sel = 3'd7; term_data = 7'd1;
    to_cyc(n + 3); term_wr = 1'b0;
    m = cyc; clear = '1;
    to_cyc(m + 1); clear = '0;
    check("t5_clear_all_expired", int'(expired), 0);
    count = 5'b10110; periodic = 5'b10100;
    expect_pulse(4, m + 4, 1'b0);
    expect_pulse(4, m + 7, 1'b0);
    expect_pulse(4, m + 13, 1'b0);
    expect_pulse(2, m + 5, 1'b0);
    expect_pulse(2, m + 9, 1'b0);
    expect_pulse(2, m + 13, 1'b0);
    expect_pulse(1, m + 7, 1'b1);
    to_cyc(m + 9); clear[4] = 1'b1;
    to_cyc(m + 10); clear[4] = 1'b0;
    check("t5_clear_wins", cv(4), 0);
    to_cyc(m + 13); count = '0;
    check("t5_expired_vec", int'(expired), 2);

    // Asynchronous reset mid-count
    n = cyc; count[0] = 1'b1;
    to_cyc(n + 30); check("t6_pre_reset_cv", cv(0), 30);
    #2 reset = 1'b1;
    #1;
    check("t6_async_count_val_nonzero", int'(count_val != '0), 0);
    check("t6_async_expired", int'(expired), 0);
    check("t6_async_timeout", int'(time_out), 0);
    to_cyc(n + 32); reset = 1'b0;
    s = cyc; count = 5'b11001; periodic = 5'b11001;
    expect_pulse(0, s + 101, 1'b0);
    expect_pulse(3, s + 101, 1'b0);
    expect_pulse(4, s + 101, 1'b0);
    to_cyc(s + 1);
    check("t6_restart_ch0", cv(0), 1);
    check("t6_restart_ch3", cv(3), 1);
    to_cyc(s + 101); count = '0;
    to_cyc(s + 104);

    foreach (sb[k]) begin
      checks++;
      errors++;
      $display("FAIL pulse_missing ch%0d: got no timeOut at cycle %0d, want 1", sb[k].ch, sb[k].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
